// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default widths for the memory arbiter
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 30;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;
endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select; a tie goes to the port that did not win last
module arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant
);
   assign grant = (req0 && req1) ? ~last_grant : req1;
endmodule

// File: rtl/mux.sv
// rtl/mux.sv - enabled 2:1 mux; drives zero when not enabled
module mux #(
   parameter int W = 1
) (
   input  logic         sel,
   input  logic         en,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] y
);
   assign y = !en ? '0 : (sel ? in1 : in0);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-memory arbiter; ARB_ROUND_ROBIN_EN enables round-robin ties
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_re,
   input  logic [DATA_W/8-1:0] m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_ready,
   input  logic                m1_re,
   input  logic [DATA_W/8-1:0] m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_ready,
   output logic                re,
   output logic [DATA_W/8-1:0] we,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   rdata,
   input  logic                mem_ready
);
   state_t state, state_d;
   logic   req0, req1, grant, last_grant, busy, sel;

   assign req0 = m0_re | (|m0_we);
   assign req1 = m1_re | (|m1_we);

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (state == IDLE && (req0 || req1))
         last_grant <= grant;
   end
`else
   // Tied high so a tie always resolves to port 0.
   assign last_grant = 1'b1;
`endif

   arb_pick u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (req0 || req1) state_d = grant ? BUSY1 : BUSY0;
         BUSY0:   if (mem_ready) state_d = IDLE;
         BUSY1:   if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state == BUSY0) || (state == BUSY1);
   assign sel  = (state == BUSY1);

   mux #(.W(1)) u_mux_re (
      .sel(sel), .en(busy), .in0(m0_re), .in1(m1_re), .y(re)
   );
   mux #(.W(DATA_W/8)) u_mux_we (
      .sel(sel), .en(busy), .in0(m0_we), .in1(m1_we), .y(we)
   );
   mux #(.W(ADDR_W)) u_mux_addr (
      .sel(sel), .en(busy), .in0(m0_addr), .in1(m1_addr), .y(addr)
   );
   mux #(.W(DATA_W)) u_mux_wdata (
      .sel(sel), .en(busy), .in0(m0_wdata), .in1(m1_wdata), .y(wdata)
   );

   assign m0_ready = (state == BUSY0) && mem_ready;
   assign m1_ready = (state == BUSY1) && mem_ready;
   assign m0_rdata = rdata;
   assign m1_rdata = rdata;
endmodule
